grostl_compress_serial_ctrl: RTL

Sequencer for the serial masked Grøstl-256 compression datapath. It accepts a start request from the hash top level and drives the datapath's register strobes, multiplexer selects, P/Q select and round number, using two cycles per round. It computes f(h,m) = P(h⊕m) ⊕ Q(m) ⊕ h in place, and tells the mask PRNG when to advance. It sits directly upstream of the compression datapath; it is the only source of that datapath's control inputs.

---
 rtl/grostl_pkg.sv | 26 ++
 rtl/grostl_compress_serial_ctrl_if.sv | 31 +++
 rtl/grostl_compress_serial_ctrl.sv | 117 +++++++++++
 3 files changed

// File: rtl/grostl_pkg.sv
// Shared constants and types for the serial masked Groestl-256 compression.
// Used by the sequencer, the datapath and the hash top level.
package grostl_pkg;

  localparam int ROUNDS_DEF = 10;

  typedef enum logic [3:0] {
    S_IDLE,
    S_LOAD,
    S_XOR,
    S_RND_A,
    S_RND_B,
    S_SAVEH,
    S_RELOAD,
    S_FINAL,
    S_DONE
  } state_t;

  localparam logic [1:0] SEL_M_MIN = 2'b00;
  localparam logic [1:0] SEL_M_RND = 2'b01;
  localparam logic [1:0] SEL_M_MHX = 2'b10;

  localparam logic SEL_PQ_P = 1'b0;
  localparam logic SEL_PQ_Q = 1'b1;

endpackage

// File: rtl/grostl_compress_serial_ctrl_if.sv
// Control bundle between the hash top level, the sequencer
// and the compression datapath.
interface grostl_compress_serial_ctrl_if;

  logic       start;
  logic       first;
  logic       busy;
  logic       done;
  logic       mask_next;
  logic       wr_m;
  logic       wr_h;
  logic [1:0] sel_m;
  logic       sel_h;
  logic       sel_pq;
  logic [3:0] round;

  modport master (
    output start, first,
    input  busy, done, mask_next,
    input  wr_m, wr_h, sel_m, sel_h,
    input  sel_pq, round
  );

  modport slave (
    input  start, first,
    output busy, done, mask_next,
    output wr_m, wr_h, sel_m, sel_h,
    output sel_pq, round
  );

endinterface

// File: rtl/grostl_compress_serial_ctrl.sv
// Two-cycle-per-round sequencer computing
// f(h,m) = P(h^m) ^ Q(m) ^ h in place on the serial datapath.
module grostl_compress_serial_ctrl
  import grostl_pkg::*;
#(
  parameter int ROUNDS = ROUNDS_DEF
) (
  input logic clk,
  input logic rst_n,
  grostl_compress_serial_ctrl_if.slave bus
);

  localparam logic [3:0] LAST = 4'(ROUNDS - 1);

  state_t     state;
  logic       pq;
  logic       first_q;
  logic [3:0] rnd;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      pq      <= 1'b0;
      first_q <= 1'b0;
      rnd     <= '0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (bus.start) begin
            first_q <= bus.first;
            state   <= S_LOAD;
          end
        end
        S_LOAD: state <= S_XOR;
        S_XOR: begin
          pq    <= 1'b0;
          rnd   <= '0;
          state <= S_RND_A;
        end
        S_RND_A: state <= S_RND_B;
        S_RND_B: begin
          if (rnd < LAST) begin
            rnd   <= rnd + 4'd1;
            state <= S_RND_A;
          end else begin
            state <= pq ? S_FINAL : S_SAVEH;
          end
        end
        S_SAVEH: state <= S_RELOAD;
        S_RELOAD: begin
          pq    <= 1'b1;
          rnd   <= '0;
          state <= S_RND_A;
        end
        S_FINAL: state <= S_DONE;
        S_DONE: begin
          pq    <= 1'b0;
          rnd   <= '0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // mask_next must precede LOAD so the PRNG has fresh masks when
  // sel_m=00 captures them; it is the only output that sees start.
  always_comb begin
    bus.busy      = 1'b1;
    bus.done      = 1'b0;
    bus.mask_next = 1'b0;
    bus.wr_m      = 1'b0;
    bus.wr_h      = 1'b0;
    bus.sel_m     = SEL_M_MHX;
    bus.sel_h     = 1'b1;
    bus.sel_pq    = SEL_PQ_P;
    unique case (state)
      S_IDLE: begin
        bus.busy      = 1'b0;
        bus.mask_next = bus.start;
      end
      S_LOAD: begin
        bus.wr_m  = 1'b1;
        bus.sel_m = SEL_M_MIN;
        bus.wr_h  = first_q;
        bus.sel_h = 1'b0;
      end
      S_XOR: bus.wr_m = 1'b1;
      S_RND_A: bus.sel_pq = pq;
      S_RND_B: begin
        bus.wr_m   = 1'b1;
        bus.sel_m  = SEL_M_RND;
        bus.sel_pq = pq;
      end
      S_SAVEH: begin
        bus.wr_h      = 1'b1;
        bus.mask_next = 1'b1;
      end
      S_RELOAD: begin
        bus.wr_m  = 1'b1;
        bus.sel_m = SEL_M_MIN;
      end
      S_FINAL: begin
        bus.wr_m = 1'b1;
        bus.wr_h = 1'b1;
      end
      S_DONE: begin
        bus.busy = 1'b0;
        bus.done = 1'b1;
      end
      default: bus.busy = 1'b0;
    endcase
  end

  assign bus.round = rnd;

endmodule
